// File: rtl/arm_ctrl_pkg.sv
// Shared control-path definitions for the multicycle ARM main controller:
// state encodings, mux-select encodings and instruction-class constants.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam int FUNCT_I = 5;
    localparam int FUNCT_L = 0;

endpackage

// File: rtl/mainfsm_if.sv
// Decoder-to-controller bundle: instruction fields in, control strobes and
// debug state out. The controller uses the master view, the datapath the slave view.
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State
    );
endinterface

// File: rtl/mainfsm_outdec.sv
// Moore output table of the main controller: every control strobe is a pure
// function of the current state; unlisted states and unused encodings drive 0.
module mainfsm_outdec
    import arm_ctrl_pkg::*;
(
    input  state_t     State,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp
);

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = ALUB_REG;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (State)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = ALUB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = ALUB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR: ALUSrcB = ALUB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = ALUB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = ALUB_IMM;
                ResultSrc = RES_ALU;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle ARM main controller: sequences fetch/decode/execute states and
// keeps a sticky flag recording that an illegal instruction class was decoded.
module mainfsm
    import arm_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mainfsm_if.master bus
);

    state_t state;
    state_t state_next;
    logic   illegal;
    logic   unused_funct;

    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = bus.Funct[FUNCT_I] ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_next = bus.Funct[FUNCT_L] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and unused codes all retire to FETCH
            default:  state_next = S_FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .State     (state),
        .IRWrite   (bus.IRWrite),
        .AdrSrc    (bus.AdrSrc),
        .ALUSrcA   (bus.ALUSrcA),
        .ALUSrcB   (bus.ALUSrcB),
        .ResultSrc (bus.ResultSrc),
        .NextPC    (bus.NextPC),
        .RegW      (bus.RegW),
        .MemW      (bus.MemW),
        .Branch    (bus.Branch),
        .ALUOp     (bus.ALUOp)
    );

    always_ff @(posedge clk) begin
        if (reset)
            illegal <= 1'b0;
        else if (state == S_DECODE && bus.Op == OP_ILL)
            illegal <= 1'b1;
    end

    assign bus.Illegal = illegal;
    assign bus.State   = state;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for the main controller: walks each instruction class through
// its state sequence and checks state, every control output and the sticky flag.
module tb_mainfsm;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    logic exp_ill;

    mainfsm_if bus ();

    mainfsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB[1:0],ResultSrc[1:0],NextPC,RegW,MemW,Branch,ALUOp}
    function automatic logic [11:0] exp_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return 12'b1_0_1_10_10_1_0_0_0_0;
            4'd1:    return 12'b0_0_1_10_10_0_0_0_0_0;
            4'd2:    return 12'b0_0_0_01_00_0_0_0_0_0;
            4'd3:    return 12'b0_1_0_00_00_0_0_0_0_0;
            4'd4:    return 12'b0_0_0_00_01_0_1_0_0_0;
            4'd5:    return 12'b0_1_0_00_00_0_0_1_0_0;
            4'd6:    return 12'b0_0_0_00_00_0_0_0_0_1;
            4'd7:    return 12'b0_0_0_01_00_0_0_0_0_1;
            4'd8:    return 12'b0_0_0_00_00_0_1_0_0_0;
            4'd9:    return 12'b0_0_0_01_10_0_0_0_1_0;
            default: return 12'b0;
        endcase
    endfunction

    function automatic logic [11:0] obs_ctrl();
        return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one cycle and check the whole observable state at the falling edge.
    task automatic step(input string tag, input logic [3:0] exp_state);
        @(negedge clk);
        check({tag, ".state"},   {8'b0, bus.State},   {8'b0, exp_state});
        check({tag, ".ctrl"},    obs_ctrl(),          exp_ctrl(exp_state));
        check({tag, ".illegal"}, {11'b0, bus.Illegal}, {11'b0, exp_ill});
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct);
        bus.Op    = op;
        bus.Funct = funct;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_ill    = 1'b0;
        reset      = 1'b1;
        set_instr(2'b00, 6'b000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.state",   {8'b0, bus.State},    12'd0);
        check("reset.ctrl",    obs_ctrl(),           exp_ctrl(4'd0));
        check("reset.illegal", {11'b0, bus.Illegal}, 12'd0);
        reset = 1'b0;

        // data-processing, register operand: 0,1,6,8,0
        step("dpr.decode", 4'd1);
        step("dpr.execr",  4'd6);
        step("dpr.aluwb",  4'd8);
        step("dpr.fetch",  4'd0);

        // load: 0,1,2,3,4,0
        set_instr(2'b01, 6'b000001);
        step("ldr.decode", 4'd1);
        step("ldr.memadr", 4'd2);
        step("ldr.memrd",  4'd3);
        step("ldr.memwb",  4'd4);
        step("ldr.fetch",  4'd0);

        // store: 0,1,2,5,0
        set_instr(2'b01, 6'b011110);
        step("str.decode", 4'd1);
        step("str.memadr", 4'd2);
        step("str.memwr",  4'd5);
        step("str.fetch",  4'd0);

        // branch: 0,1,9,0
        set_instr(2'b10, 6'b100001);
        step("br.decode", 4'd1);
        step("br.branch", 4'd9);
        step("br.fetch",  4'd0);

        // data-processing, immediate operand: 0,1,7,8,0
        set_instr(2'b00, 6'b100000);
        step("dpi.decode", 4'd1);
        step("dpi.execi",  4'd7);
        step("dpi.aluwb",  4'd8);
        step("dpi.fetch",  4'd0);

        // illegal class: 0,1,10,0 and the flag sticks through later instructions
        set_instr(2'b11, 6'b000000);
        step("ill.decode", 4'd1);
        exp_ill = 1'b1;
        step("ill.unknown", 4'd10);
        step("ill.fetch",   4'd0);
        set_instr(2'b00, 6'b000000);
        step("ill.next_decode", 4'd1);
        step("ill.next_execr",  4'd6);
        step("ill.next_aluwb",  4'd8);
        step("ill.next_fetch",  4'd0);

        // reset during MEMRD abandons the load and clears the flag
        set_instr(2'b01, 6'b000001);
        step("rst.decode", 4'd1);
        step("rst.memadr", 4'd2);
        step("rst.memrd",  4'd3);
        reset   = 1'b1;
        exp_ill = 1'b0;
        step("rst.fetch", 4'd0);
        reset = 1'b0;
        step("rst.redo_decode", 4'd1);
        step("rst.redo_memadr", 4'd2);
        step("rst.redo_memrd",  4'd3);
        step("rst.redo_memwb",  4'd4);
        step("rst.redo_fetch",  4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
